// File: rtl/flocra_rx_cfg_axi_if.sv
// AXI4-Lite bus bundle between the PS initiator and the RX chain configuration block.
interface flocra_rx_cfg_axi_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/flocra_rx_cfg_axi.sv
// AXI4-Lite register block holding RX0/RX1 decimation, DDS source and chain reset, plus a write counter.
//
// state  | meaning
// W_IDLE | waiting for address and data valid together
// W_ACK  | awready/wready high, write commits on the next edge
// W_RESP | bvalid held until bready
// R_IDLE | waiting for arvalid
// R_ACK  | arready high, read data captured on the next edge
// R_DATA | rvalid held until rready
module flocra_rx_cfg_axi #(
    parameter int C_S0_AXI_ADDR_WIDTH = 19,
    parameter int C_S0_AXI_DATA_WIDTH = 32
) (
    input  logic               s0_axi_aclk,
    input  logic               s0_axi_aresetn,
    flocra_rx_cfg_axi_if.slave s0_axi,
    output logic [9:0]         rx0_rate_o,
    output logic [1:0]         rx0_dds_source_o,
    output logic               rx0_rst_n_o,
    output logic [9:0]         rx1_rate_o,
    output logic [1:0]         rx1_dds_source_o,
    output logic               rx1_rst_n_o
);
    localparam int AW = C_S0_AXI_ADDR_WIDTH;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_e;

    w_state_e w_state, w_next;
    r_state_e r_state, r_next;

    logic [12:0] rx0_ctrl;
    logic [12:0] rx1_ctrl;
    logic [31:0] scratch;
    logic [15:0] wrcnt;
    logic [1:0]  bresp_q;
    logic [1:0]  rresp_q;
    logic [C_S0_AXI_DATA_WIDTH-1:0] rdata_q;

    logic        wr_err;
    logic [1:0]  wr_sel;
    logic [31:0] wr_old;
    logic [31:0] wr_new;
    logic        rd_err;
    logic [31:0] rd_val;
    logic        unused_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (s0_axi.awvalid && s0_axi.wvalid) w_next = W_ACK;
            W_ACK:   w_next = W_RESP;
            W_RESP:  if (s0_axi.bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (s0_axi.arvalid) r_next = R_ACK;
            R_ACK:   r_next = R_DATA;
            R_DATA:  if (s0_axi.rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // WRCNT is read-only, so writing it is reported like an unmapped address
    always_comb begin
        wr_sel = s0_axi.awaddr[3:2];
        wr_err = (|s0_axi.awaddr[AW-1:4]) || (wr_sel == 2'd2);
        wr_old = 32'd0;
        case (wr_sel)
            2'd0:    wr_old = {19'd0, rx0_ctrl};
            2'd1:    wr_old = {19'd0, rx1_ctrl};
            2'd3:    wr_old = scratch;
            default: wr_old = 32'd0;
        endcase
        wr_new = merge_bytes(wr_old, s0_axi.wdata, s0_axi.wstrb);
    end

    always_comb begin
        rd_err = |s0_axi.araddr[AW-1:4];
        rd_val = 32'd0;
        if (!rd_err) begin
            case (s0_axi.araddr[3:2])
                2'd0:    rd_val = {19'd0, rx0_ctrl};
                2'd1:    rd_val = {19'd0, rx1_ctrl};
                2'd2:    rd_val = {16'd0, wrcnt};
                default: rd_val = scratch;
            endcase
        end
    end

    always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
            rx0_ctrl <= 13'd0;
            rx1_ctrl <= 13'd0;
            scratch  <= 32'd0;
            wrcnt    <= 16'd0;
            bresp_q  <= RESP_OKAY;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            if (w_state == W_ACK) begin
                bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
                if (!wr_err) begin
                    case (wr_sel)
                        2'd0:    rx0_ctrl <= wr_new[12:0];
                        2'd1:    rx1_ctrl <= wr_new[12:0];
                        2'd3:    scratch  <= wr_new;
                        default: ;
                    endcase
                    wrcnt <= wrcnt + 16'd1;
                end
            end
            // Registers only change at the commit edge, so a read captured on that edge sees the old value
            if (r_state == R_ACK) begin
                rdata_q <= rd_val;
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign s0_axi.awready = (w_state == W_ACK);
    assign s0_axi.wready  = (w_state == W_ACK);
    assign s0_axi.bvalid  = (w_state == W_RESP);
    assign s0_axi.bresp   = bresp_q;
    assign s0_axi.arready = (r_state == R_ACK);
    assign s0_axi.rvalid  = (r_state == R_DATA);
    assign s0_axi.rdata   = rdata_q;
    assign s0_axi.rresp   = rresp_q;

    assign rx0_rate_o       = rx0_ctrl[9:0];
    assign rx0_dds_source_o = rx0_ctrl[11:10];
    assign rx0_rst_n_o      = rx0_ctrl[12];
    assign rx1_rate_o       = rx1_ctrl[9:0];
    assign rx1_dds_source_o = rx1_ctrl[11:10];
    assign rx1_rst_n_o      = rx1_ctrl[12];

    assign unused_bits = ^{s0_axi.awprot, s0_axi.arprot, s0_axi.awaddr[1:0], s0_axi.araddr[1:0]};
endmodule

// File: tb/tb_flocra_rx_cfg_axi.sv
// Bench for flocra_rx_cfg_axi: directed register-map cases with literal expectations plus
// randomized traffic checked against a register-map model by a per-cycle monitor.
module tb_flocra_rx_cfg_axi;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [9:0] rx0_rate, rx1_rate;
    logic [1:0] rx0_dds, rx1_dds;
    logic       rx0_rst_n, rx1_rst_n;

    int checks = 0;
    int failures = 0;

    flocra_rx_cfg_axi_if #(.ADDR_WIDTH(19), .DATA_WIDTH(32)) bus ();

    flocra_rx_cfg_axi #(.C_S0_AXI_ADDR_WIDTH(19), .C_S0_AXI_DATA_WIDTH(32)) dut (
        .s0_axi_aclk      (clk),
        .s0_axi_aresetn   (rst_n),
        .s0_axi           (bus),
        .rx0_rate_o       (rx0_rate),
        .rx0_dds_source_o (rx0_dds),
        .rx0_rst_n_o      (rx0_rst_n),
        .rx1_rate_o       (rx1_rate),
        .rx1_dds_source_o (rx1_dds),
        .rx1_rst_n_o      (rx1_rst_n)
    );

    always #5 clk = ~clk;

    // Register-map model
    logic [12:0] m_rx0, m_rx1;
    logic [31:0] m_scratch;
    int          m_wrcnt;
    logic [1:0]  bexp_q[$];
    logic [33:0] rexp_q[$];
    logic [1:0]  mon_resp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_reg(input logic [18:0] addr);
        if (addr[18:4] != 15'd0) return 32'd0;
        case (addr[3:2])
            2'd0:    return {19'd0, m_rx0};
            2'd1:    return {19'd0, m_rx1};
            2'd2:    return m_wrcnt;
            default: return m_scratch;
        endcase
    endfunction

    task automatic model_write(input logic [18:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        logic [31:0] v;
        if (addr[18:4] != 15'd0 || addr[3:2] == 2'd2) begin
            resp = 2'b10;
            return;
        end
        v = model_reg(addr);
        for (int b = 0; b < 4; b++) if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
        case (addr[3:2])
            2'd0:    m_rx0 = v[12:0];
            2'd1:    m_rx1 = v[12:0];
            default: m_scratch = v;
        endcase
        m_wrcnt = (m_wrcnt + 1) % 65536;
        resp = 2'b00;
    endtask

    // Monitor: compares against the model every cycle, then applies the handshakes due at the next edge
    always @(negedge clk) begin
        if (!rst_n) begin
            m_rx0 = 13'd0;
            m_rx1 = 13'd0;
            m_scratch = 32'd0;
            m_wrcnt = 0;
            bexp_q.delete();
            rexp_q.delete();
        end else begin
            check("rx0_outputs", {19'd0, rx0_rst_n, rx0_dds, rx0_rate}, {19'd0, m_rx0});
            check("rx1_outputs", {19'd0, rx1_rst_n, rx1_dds, rx1_rate}, {19'd0, m_rx1});
            if (bus.awready || bus.wready)
                check("ready_pair", {bus.awready, bus.wready, bus.awvalid, bus.wvalid}, 4'hF);
            if (bus.arready) check("arready_with_arvalid", bus.arvalid, 1);
            if (bus.bvalid) begin
                if (bexp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL bvalid_unexpected: got bvalid=1 required no response pending");
                end else begin
                    check("bresp", bus.bresp, bexp_q[0]);
                    if (bus.bready) void'(bexp_q.pop_front());
                end
            end
            if (bus.rvalid) begin
                if (rexp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rvalid_unexpected: got rvalid=1 required no read pending");
                end else begin
                    check("rdata", bus.rdata, rexp_q[0][31:0]);
                    check("rresp", bus.rresp, rexp_q[0][33:32]);
                    if (bus.rready) void'(rexp_q.pop_front());
                end
            end
            if (bus.arvalid && bus.arready)
                rexp_q.push_back({(bus.araddr[18:4] != 15'd0) ? 2'b10 : 2'b00, model_reg(bus.araddr)});
            if (bus.awvalid && bus.awready && bus.wvalid && bus.wready) begin
                model_write(bus.awaddr, bus.wdata, bus.wstrb, mon_resp);
                bexp_q.push_back(mon_resp);
            end
        end
    end

    task automatic axi_write(input logic [18:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int lead, input bit lead_w, input int bdelay, output logic [1:0] resp);
        int n;
        bus.awaddr = addr;
        bus.wdata  = data;
        bus.wstrb  = strb;
        if (lead > 0) begin
            if (lead_w) bus.wvalid = 1'b1;
            else        bus.awvalid = 1'b1;
            repeat (lead) begin
                @(posedge clk); #1;
                check("single_valid_no_ready", {bus.awready, bus.wready}, 2'b00);
            end
        end
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        @(posedge clk); #1;
        check("aw_ready_latency", {bus.awready, bus.wready}, 2'b11);
        n = 0;
        while (!bus.awready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.awready) begin
            checks++;
            failures++;
            $display("FAIL aw_ready_timeout: got awready=0 required 1 within 8 cycles");
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
            resp = 2'b11;
            return;
        end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("aw_ready_one_cycle", {bus.awready, bus.wready}, 2'b00);
        check("bvalid_after_commit", bus.bvalid, 1);
        resp = bus.bresp;
        repeat (bdelay) begin
            @(posedge clk); #1;
            check("bvalid_held", {bus.bvalid, bus.bresp}, {1'b1, resp});
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        check("bvalid_clear", bus.bvalid, 0);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [18:0] addr, input int rdelay,
                            output logic [31:0] data, output logic [1:0] resp);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        @(posedge clk); #1;
        check("ar_ready_latency", bus.arready, 1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        check("ar_ready_one_cycle", bus.arready, 0);
        check("rvalid_after_capture", bus.rvalid, 1);
        data = bus.rdata;
        resp = bus.rresp;
        repeat (rdelay) begin
            @(posedge clk); #1;
            check("rdata_held", {bus.rvalid, bus.rresp, bus.rdata[28:0]}, {1'b1, resp, data[28:0]});
        end
        bus.rready = 1'b1;
        @(posedge clk); #1;
        check("rvalid_clear", bus.rvalid, 0);
        bus.rready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: time limit reached before end of test");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, tmp;
        logic [1:0]  rr, wr;
        logic [18:0] a_w, a_r;
        int op;

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0;
        bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 0; bus.bready = 0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0; bus.rready = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_valids", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 5'd0);
        check("reset_resp_data", {bus.bresp, bus.rresp, bus.rdata[27:0]}, 32'd0);
        check("reset_rx_outputs", {rx0_rate, rx0_dds, rx0_rst_n, rx1_rate, rx1_dds, rx1_rst_n}, 26'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            axi_read(19'(4 * i), 0, rd, rr);
            check("reset_read", {rr, rd[29:0]}, 32'd0);
            check("reset_read_hi", rd, 32'd0);
        end

        axi_write(19'h0, 32'h0000_1805, 4'hF, 0, 0, 0, wr);
        check("rx0_write_bresp", wr, 2'b00);
        check("rx0_rate", rx0_rate, 5);
        check("rx0_dds", rx0_dds, 2);
        check("rx0_rst_n", rx0_rst_n, 1);
        check("rx1_untouched", {rx1_rate, rx1_dds, rx1_rst_n}, 13'd0);
        axi_read(19'h8, 0, rd, rr);
        check("wrcnt_after_one", rd, 1);

        axi_write(19'hC, 32'hAABB_CCDD, 4'hF, 0, 0, 1, wr);
        axi_write(19'hC, 32'h1122_3344, 4'b0101, 0, 0, 0, wr);
        axi_read(19'hC, 2, rd, rr);
        check("scratch_byte_lanes", rd, 32'hAA22_CC44);

        axi_write(19'h8, 32'h0000_FFFF, 4'hF, 0, 0, 0, wr);
        check("wrcnt_write_slverr", wr, 2'b10);
        axi_write(19'h10, 32'h1234_5678, 4'hF, 0, 0, 0, wr);
        check("high_addr_write_slverr", wr, 2'b10);
        axi_read(19'h8, 0, rd, rr);
        check("wrcnt_after_errors", rd, 3);
        axi_read(19'h40, 0, rd, rr);
        check("high_addr_read", {rr, rd[29:0]}, {2'b10, 30'd0});

        axi_write(19'h4, 32'hFFFF_FFFF, 4'hF, 5, 0, 10, wr);
        check("rx1_all_ones", {rx1_rst_n, rx1_dds, rx1_rate}, 13'h1FFF);
        axi_write(19'hC, 32'h0BAD_F00D, 4'hF, 4, 1, 3, wr);
        axi_read(19'hC, 6, rd, rr);
        check("scratch_after_wlead", rd, 32'h0BAD_F00D);

        fork
            axi_read(19'h8, 0, rd, rr);
            axi_write(19'h4, 32'h0000_0123, 4'h3, 0, 0, 0, wr);
        join
        check("overlap_old_count", rd, 5);
        axi_read(19'h8, 0, rd, rr);
        check("overlap_new_count", rd, 6);

        for (int i = 0; i < 250; i++) begin
            op  = $urandom_range(0, 2);
            tmp = $urandom;
            a_w = ($urandom_range(0, 9) < 8) ? {15'd0, tmp[3:0]} : (tmp[18:0] | 19'h10);
            tmp = $urandom;
            a_r = ($urandom_range(0, 9) < 8) ? {15'd0, tmp[7:4]} : (tmp[18:0] | 19'h20);
            tmp = $urandom;
            if (op == 0) begin
                axi_write(a_w, $urandom, tmp[3:0], $urandom_range(0, 2), tmp[4],
                          $urandom_range(0, 3), wr);
            end else if (op == 1) begin
                axi_read(a_r, $urandom_range(0, 3), rd, rr);
            end else begin
                fork
                    axi_write(a_w, $urandom, tmp[3:0], 0, 0, $urandom_range(0, 2), wr);
                    axi_read(a_r, $urandom_range(0, 2), rd, rr);
                join
            end
        end

        for (int i = 0; i < 200; i++) begin
            axi_write(19'h0, $urandom, 4'hF, 0, 0, 0, wr);
        end
        axi_read(19'h8, 0, rd, rr);

        // Reset while a read is holding data and a write is being acknowledged
        bus.araddr  = 19'hC;
        bus.arvalid = 1'b1;
        @(posedge clk); #1;
        bus.awaddr  = 19'h0;
        bus.wdata   = 32'h0000_1FFF;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midreset_valids", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 5'd0);
        check("midreset_rdata", bus.rdata, 32'd0);
        check("midreset_rx", {rx0_rate, rx0_dds, rx0_rst_n, rx1_rate, rx1_dds, rx1_rst_n}, 26'd0);
        bus.arvalid = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_read(19'h0, 0, rd, rr);
        check("post_reset_rx0", rd, 32'd0);
        axi_read(19'h8, 0, rd, rr);
        check("post_reset_wrcnt", rd, 32'd0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
